// File: rtl/execute_muldiv.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
// While an operation is in progress it holds the front of the pipeline with stall_E.
// For one cycle afterwards it presents a registered result with a done pulse.
// Optional build macro: MULDIV_FAST_MUL_EN. When defined, multiplies finish in a
// single combinational step instead of iterating.
module execute_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_E,
  input  logic                  flush_E,
  input  logic [2:0]            funct3_E,
  input  logic [DATA_WIDTH-1:0] op1_E,
  input  logic [DATA_WIDTH-1:0] op2_E,
  output logic                  busy,
  output logic                  done,
  output logic                  stall_E,
  output logic [DATA_WIDTH-1:0] result_E
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST    = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [W-1:0]         MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [W-1:0]         accHi_q, accHi_d;
  logic [W-1:0]         accLo_q, accLo_d;
  logic [W-1:0]         opB_q, opB_d;
  logic                 resNeg_q, resNeg_d;
  logic [W-1:0]         result_q, result_d;

  logic                 isDivE, isRemE, op1Signed, op2Signed, sign1, sign2;
  logic [W-1:0]         mag1E, mag2E;
  logic                 negE, divZeroE, ovflE, specialE;
  logic [W-1:0]         specialRes;

  logic [W:0]           mulSum, divShift, divDiff;
  logic                 divBit;
  logic [W-1:0]         stepHi, stepLo, divSel, finalResult;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0]       fastProd;
`endif

  // Sign-correct a double-width product and pick the low half (MUL) or the high half.
  function automatic logic [W-1:0] mulSelect(input logic [2*W-1:0] prod,
                                              input logic neg,
                                              input logic [1:0] sel);
    logic [2*W-1:0] p;
    p = neg ? -prod : prod;
    return (sel == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // Decode the incoming E-stage op: operand signedness, magnitudes, result sign and special divides.
  always_comb begin
    isDivE = funct3_E[2];
    isRemE = funct3_E[2] & funct3_E[1];
    case (funct3_E)
      3'b000, 3'b001, 3'b100, 3'b110: {op1Signed, op2Signed} = 2'b11;
      3'b010:                         {op1Signed, op2Signed} = 2'b10;
      default:                        {op1Signed, op2Signed} = 2'b00;
    endcase
    sign1      = op1Signed & op1_E[W-1];
    sign2      = op2Signed & op2_E[W-1];
    mag1E      = sign1 ? -op1_E : op1_E;
    mag2E      = sign2 ? -op2_E : op2_E;
    negE       = sign1 ^ (sign2 & ~isRemE);
    divZeroE   = isDivE & (op2_E == '0);
    ovflE      = isDivE & ~funct3_E[0] & (op1_E == MIN_NEG) & (op2_E == '1);
    specialE   = divZeroE | ovflE;
    if (divZeroE) begin
      specialRes = isRemE ? op1_E : '1;
    end else begin
      specialRes = isRemE ? '0 : op1_E;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Full-width product of the magnitudes, used to finish a multiply straight from IDLE.
  always_comb begin
    fastProd = {{W{1'b0}}, mag1E} * {{W{1'b0}}, mag2E};
  end
`endif

  // One iteration of shift-add multiply or restoring divide.
  // Multiply: accHi holds the partial product and accLo the multiplier.
  // Divide:   accHi holds the partial remainder and accLo the dividend/quotient.
  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : '0);
    divShift = {accHi_q, accLo_q[W-1]};
    divDiff  = divShift - {1'b0, opB_q};
    divBit   = ~divDiff[W];
    if (funct3_q[2]) begin
      stepHi = divBit ? divDiff[W-1:0] : divShift[W-1:0];
      stepLo = {accLo_q[W-2:0], divBit};
    end else begin
      stepHi = mulSum[W:1];
      stepLo = {mulSum[0], accLo_q[W-1:1]};
    end
  end

  // Build the sign-corrected result from the last iteration for loading on entry to DONE.
  always_comb begin
    divSel = funct3_q[1] ? stepHi : stepLo;
    if (funct3_q[2]) begin
      finalResult = resNeg_q ? -divSel : divSel;
    end else begin
      finalResult = mulSelect({stepHi, stepLo}, resNeg_q, funct3_q[1:0]);
    end
  end

  // Next-state logic: accept in IDLE, iterate in CALC, then a single DONE cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    accHi_d  = accHi_q;
    accLo_d  = accLo_q;
    opB_d    = opB_q;
    resNeg_d = resNeg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_E && !flush_E) begin
          funct3_d = funct3_E;
          resNeg_d = negE;
          cnt_d    = '0;
          accHi_d  = '0;
          accLo_d  = isDivE ? mag1E : mag2E;
          opB_d    = isDivE ? mag2E : mag1E;
          if (specialE) begin
            result_d = specialRes;
            state_d  = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!isDivE) begin
            result_d = mulSelect(fastProd, negE, funct3_E[1:0]);
            state_d  = DONE;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush_E) begin
          state_d = IDLE;
        end else begin
          accHi_d = stepHi;
          accLo_d = stepLo;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == LAST) begin
            result_d = finalResult;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      accHi_q  <= '0;
      accLo_q  <= '0;
      opB_q    <= '0;
      resNeg_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      accHi_q  <= accHi_d;
      accLo_q  <= accLo_d;
      opB_q    <= opB_d;
      resNeg_q <= resNeg_d;
      result_q <= result_d;
    end
  end

  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);
  assign stall_E  = (start_E && (state_q == IDLE) && !flush_E) || (state_q == CALC);
  assign result_E = result_q;

endmodule
